// File: rtl/m_seg_scan.sv
// Purpose: scans six BCD time digits onto a multiplexed common-anode 7-segment display.
// Latency: one registered stage from counter state and inputs to seg/dp/an.
// Backpressure: none; free-running scan, inputs sampled every cycle.
module m_seg_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 16,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hour_high,
    input  logic [3:0] hour_low,
    input  logic [3:0] min_high,
    input  logic [3:0] min_low,
    input  logic [3:0] sec_high,
    input  logic [3:0] sec_low,
    input  logic [1:0] blink_sel,
    input  logic       blink_phase,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_C   = CW'(DEAD);

    localparam logic [1:0] BLINK_NONE = 2'd0;
    localparam logic [1:0] BLINK_HOUR = 2'd1;
    localparam logic [1:0] BLINK_MIN  = 2'd2;
    localparam logic [1:0] BLINK_SEC  = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          wrap;

    logic [3:0]    digit;
    logic          field_hit;
    logic          lz_blank;
    logic          dark;
    logic          lit;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [5:0]    an_nxt;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes are blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign wrap = (cnt == CNT_LAST);

    // Slot counter: counts cycles inside one digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit index: advances once per slot, recovering to 0 from any out-of-range value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 3'd0;
        end else if (wrap) begin
            idx <= (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
        end
    end

    // Select the BCD digit for the current slot, rightmost digit first.
    always_comb begin
        digit = 4'hF;
        case (idx)
            3'd0:    digit = sec_low;
            3'd1:    digit = sec_high;
            3'd2:    digit = min_low;
            3'd3:    digit = min_high;
            3'd4:    digit = hour_low;
            3'd5:    digit = hour_high;
            default: digit = 4'hF;
        endcase
    end

    // Work out whether the current slot is in the field being blinked.
    always_comb begin
        field_hit = 1'b0;
        case (blink_sel)
            BLINK_NONE: field_hit = 1'b0;
            BLINK_HOUR: field_hit = (idx == 3'd4) || (idx == 3'd5);
            BLINK_MIN:  field_hit = (idx == 3'd2) || (idx == 3'd3);
            BLINK_SEC:  field_hit = (idx == 3'd0) || (idx == 3'd1);
            default:    field_hit = 1'b0;
        endcase
    end

    // Next segment/dp/anode values; anode is held off during the dead time
    // so the previous digit's pattern never ghosts onto the new anode.
    always_comb begin
        lz_blank = BLANK_LZ && (idx == 3'd5) && (hour_high == 4'd0);
        dark     = blink_phase && field_hit;
        lit      = (cnt >= DEAD_C);

        seg_nxt = bcd_to_seg(digit);
        dp_nxt  = !((idx == 3'd2) || (idx == 3'd4));
        if (lz_blank) begin
            seg_nxt = SEG_BLANK;
        end
        if (dark) begin
            seg_nxt = SEG_BLANK;
            dp_nxt  = 1'b1;
        end

        // Shifting past bit 5 for idx 6/7 leaves every anode off.
        an_nxt = lit ? ~(6'd1 << idx) : 6'h3F;
    end

    // Output registers: no combinational path from inputs to pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= 6'h3F;
        end else begin
            seg <= seg_nxt;
            dp  <= dp_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_m_seg_scan.sv
module tb_m_seg_scan;

    logic       clk;
    logic       rst_n;
    logic [3:0] hour_high, hour_low, min_high, min_low, sec_high, sec_low;
    logic [1:0] blink_sel;
    logic       blink_phase;
    logic [6:0] seg, seg_nolz;
    logic       dp, dp_nolz;
    logic [5:0] an, an_nolz;

    int vectors;
    int miscompares;
    int edges;

    m_seg_scan #(.SCAN_DIV(8), .DEAD(2), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .hour_high(hour_high), .hour_low(hour_low),
        .min_high(min_high), .min_low(min_low),
        .sec_high(sec_high), .sec_low(sec_low),
        .blink_sel(blink_sel), .blink_phase(blink_phase),
        .seg(seg), .dp(dp), .an(an)
    );

    m_seg_scan #(.SCAN_DIV(8), .DEAD(2), .BLANK_LZ(1'b0)) u_dut_nolz (
        .clk(clk), .rst_n(rst_n),
        .hour_high(hour_high), .hour_low(hour_low),
        .min_high(min_high), .min_low(min_low),
        .sec_high(sec_high), .sec_low(sec_low),
        .blink_sel(blink_sel), .blink_phase(blink_phase),
        .seg(seg_nolz), .dp(dp_nolz), .an(an_nolz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges since reset released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic set_time(input logic [3:0] hh, hl, mh, ml, sh, sl);
        hour_high = hh; hour_low = hl;
        min_high  = mh; min_low  = ml;
        sec_high  = sh; sec_low  = sl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sample point: falling edge right after rising edge k.
    task automatic goto(input int k);
        int budget;
        budget = 0;
        @(negedge clk);
        while (edges != k && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (edges != k) begin
            vectors++;
            miscompares++;
            $display("FAIL goto timeout: edges=%0d required=%0d", edges, k);
        end
    endtask

    task automatic test_reset();
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
        blink_sel = 2'd0; blink_phase = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hold: an=%h seg=%h dp=%b required an=3f seg=7f dp=1", an, seg, dp);
        end
        rst_n = 1'b1;
        goto(2);
        vectors++;
        if (an !== 6'h3F) begin
            miscompares++;
            $display("FAIL reset_edge2_an: an=%h required 3f", an);
        end
        goto(3);
        vectors++;
        if (an !== 6'h3E || seg !== 7'h00) begin
            miscompares++;
            $display("FAIL reset_edge3: an=%h seg=%h required an=3e seg=00", an, seg);
        end
        goto(5);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: an=%h seg=%h dp=%b required an=3f seg=7f dp=1", an, seg, dp);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [5:0] exp_an  [6];
        logic [6:0] exp_seg [6];
        logic       exp_dp  [6];
        int dark_cnt;
        exp_an  = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        exp_seg = '{7'h00, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24};
        exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
        blink_sel = 2'd0; blink_phase = 1'b0;
        do_reset();
        for (int s = 0; s < 6; s++) begin
            dark_cnt = 0;
            for (int p = 0; p < 8; p++) begin
                goto(s * 8 + p + 1);
                if (an == 6'h3F) dark_cnt++;
                if (p >= 2) begin
                    vectors++;
                    if (an !== exp_an[s] || seg !== exp_seg[s] || dp !== exp_dp[s]) begin
                        miscompares++;
                        $display("FAIL scan slot%0d pos%0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                                 s, p, an, seg, dp, exp_an[s], exp_seg[s], exp_dp[s]);
                    end
                end
            end
            vectors++;
            if (dark_cnt != 2) begin
                miscompares++;
                $display("FAIL dead_time slot%0d: dark cycles=%0d required 2", s, dark_cnt);
            end
        end
    endtask

    task automatic test_leading_zero();
        set_time(4'd0, 4'd5, 4'd5, 4'd9, 4'd5, 4'd8);
        blink_sel = 2'd0; blink_phase = 1'b0;
        do_reset();
        goto(35);
        vectors++;
        if (an !== 6'h2F || seg !== 7'h12) begin
            miscompares++;
            $display("FAIL lz_05_idx4: an=%h seg=%h required an=2f seg=12", an, seg);
        end
        goto(43);
        vectors++;
        if (an !== 6'h1F || seg !== 7'h7F) begin
            miscompares++;
            $display("FAIL lz_05_idx5: an=%h seg=%h required an=1f seg=7f", an, seg);
        end
        vectors++;
        if (an_nolz !== 6'h1F || seg_nolz !== 7'h40) begin
            miscompares++;
            $display("FAIL nolz_idx5: an=%h seg=%h required an=1f seg=40", an_nolz, seg_nolz);
        end
        set_time(4'd0, 4'd0, 4'd5, 4'd9, 4'd5, 4'd8);
        do_reset();
        goto(35);
        vectors++;
        if (an !== 6'h2F || seg !== 7'h40) begin
            miscompares++;
            $display("FAIL lz_00_idx4: an=%h seg=%h required an=2f seg=40", an, seg);
        end
        goto(43);
        vectors++;
        if (an !== 6'h1F || seg !== 7'h7F) begin
            miscompares++;
            $display("FAIL lz_00_idx5: an=%h seg=%h required an=1f seg=7f", an, seg);
        end
    endtask

    task automatic test_invalid_bcd();
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'hC);
        blink_sel = 2'd0; blink_phase = 1'b0;
        do_reset();
        goto(3);
        vectors++;
        if (an !== 6'h3E || seg !== 7'h7F) begin
            miscompares++;
            $display("FAIL invalid_idx0: an=%h seg=%h required an=3e seg=7f", an, seg);
        end
        goto(11);
        vectors++;
        if (an !== 6'h3D || seg !== 7'h12) begin
            miscompares++;
            $display("FAIL invalid_idx1: an=%h seg=%h required an=3d seg=12", an, seg);
        end
    endtask

    task automatic test_blink();
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
        blink_sel = 2'd2; blink_phase = 1'b1;
        do_reset();
        goto(11);
        vectors++;
        if (an !== 6'h3D || seg !== 7'h12 || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL blink_idx1: an=%h seg=%h dp=%b required an=3d seg=12 dp=1", an, seg, dp);
        end
        goto(19);
        vectors++;
        if (an !== 6'h3B || seg !== 7'h7F || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL blink_idx2: an=%h seg=%h dp=%b required an=3b seg=7f dp=1", an, seg, dp);
        end
        goto(27);
        vectors++;
        if (an !== 6'h37 || seg !== 7'h7F || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL blink_idx3: an=%h seg=%h dp=%b required an=37 seg=7f dp=1", an, seg, dp);
        end
        do_reset();
        goto(19);
        blink_phase = 1'b0;
        goto(20);
        vectors++;
        if (an !== 6'h3B || seg !== 7'h10 || dp !== 1'b0) begin
            miscompares++;
            $display("FAIL unblink_idx2: an=%h seg=%h dp=%b required an=3b seg=10 dp=0", an, seg, dp);
        end
        blink_sel = 2'd0;
    endtask

    task automatic test_mid_slot();
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
        blink_sel = 2'd0; blink_phase = 1'b0;
        do_reset();
        goto(20);
        vectors++;
        if (an !== 6'h3B || seg !== 7'h10) begin
            miscompares++;
            $display("FAIL midslot_before: an=%h seg=%h required an=3b seg=10", an, seg);
        end
        min_low = 4'd0;
        goto(21);
        vectors++;
        if (an !== 6'h3B || seg !== 7'h40 || dp !== 1'b0) begin
            miscompares++;
            $display("FAIL midslot_after: an=%h seg=%h dp=%b required an=3b seg=40 dp=0", an, seg, dp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        blink_sel   = 2'd0;
        blink_phase = 1'b0;
        test_reset();
        test_scan();
        test_leading_zero();
        test_invalid_bcd();
        test_blink();
        test_mid_slot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m_seg_scan.md
# m_seg_scan

Display-side reader for the stopwatch's BCD time digits. It takes the six BCD digits (hours, minutes, seconds) produced by the time-generation counters and drives a 6-digit, time-multiplexed, common-anode 7-segment display. It provides:
- segment decode,
- anode scanning with anti-ghosting dead time,
- leading-zero blanking on the hour tens digit,
- decimal-point separators,
- per-field blinking for time-set mode.

## Interface
- SCAN_DIV, 50000, clock cycles per digit slot; legal range is 4 or more.
- DEAD, 16, cycles at the start of each slot with all anodes off; legal range is 1 to SCAN_DIV-2.
- BLANK_LZ, 1, when 1 a zero on hour_high is blanked.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hour_high, hour_low, min_high, min_low, sec_high, sec_low  in  4 each  BCD digits, not required to be synchronous to the slot.
- blink_sel  in  2  field to blink: 0 none, 1 hours, 2 minutes, 3 seconds.
- blink_phase  in  1  blink half-period; 1 means the selected field is dark.
- seg  out  7  active-low segments, packed {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- an  out  6  active-low anodes; an[0] is the rightmost digit.

## Operation
- **Slot counter.** cnt, width $clog2(SCAN_DIV), counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap, idx (3 bits) advances 0,1,2,3,4,5,0,…; idx never holds 6 or 7.
  - If idx is ever 6 or 7, the next advance sets it to 0.
- **Digit map.** idx 0=sec_low, 1=sec_high, 2=min_low, 3=min_high, 4=hour_low, 5=hour_high.
- **Decode.** seg values for digits 0–9: 40,79,24,30,19,12,02,78,00,10 (hex). Input codes 10–15 give 7F (blank).
- **Leading-zero blanking.** When BLANK_LZ=1, idx=5 and hour_high=0, seg=7F. The anode still follows the normal scan. hour_low is never blanked.
- **Separators.** dp=0 on idx 2 and idx 4; otherwise dp=1.
- **Blink.** When blink_phase=1 and idx belongs to the field selected by blink_sel (hours = idx 4,5; minutes = idx 2,3; seconds = idx 0,1):
  - seg=7F and dp=1;
  - the anode follows the normal scan.
- **Anode drive.** an[idx]=0 only when cnt ≥ DEAD; all other an bits are 1.
- **Output registers.** seg, dp and an are registered. On each edge they are computed from the pre-edge values of cnt, idx and all inputs. No combinational path runs from any input to any output.

## Timing
- **Reset (async, immediate):** cnt=0, idx=0, an=6'b111111, seg=7'h7F, dp=1. Reset asserted mid-slot forces these values at once, without waiting for a clock edge.
- **Edge numbering:** edge k is the k-th rising edge after rst_n rises.
  - After edge k within the first slot, cnt=k and the outputs reflect cnt=k-1.
  - an[0] first goes low after edge DEAD+1.
  - The first wrap occurs at edge SCAN_DIV: idx becomes 1 and cnt becomes 0.
- **Slot timing:** each slot lasts exactly SCAN_DIV cycles. an is all-ones for DEAD cycles, then one anode is low for SCAN_DIV-DEAD cycles. The full frame is 6·SCAN_DIV cycles.
- **Slot transitions:**
  - The anode of the old digit turns off on the same edge that seg switches to the new digit.
  - No cycle has an anode low while seg belongs to a different digit.
- **Input latency:**
  - A change on a digit, blink_sel or blink_phase reaches seg/dp one cycle after it is sampled, provided the corresponding digit is the active one.
  - Digit changes mid-slot are displayed mid-slot; no per-slot snapshot is taken.
- **Simultaneous events:** a digit change on the same edge as a slot wrap is decoded for the new idx on the following edge.

## Test plan
Directed scenarios use SCAN_DIV=8 and DEAD=2.
- **Reset:** hold rst_n=0 → an=3F, seg=7F, dp=1. Release and count edges → an=3E first after edge 3. Assert rst_n asynchronously mid-slot → outputs return to reset values within the same cycle.
- **Scan/decode:** digits 23:59:58, blink_sel=0. Over one 48-cycle frame, the lit-phase pairs (an, seg, dp) must be:
  - 3E/00/1
  - 3D/12/1
  - 3B/10/0
  - 37/12/1
  - 2F/30/0
  - 1F/24/1
  - In each slot, an=3F for exactly 2 cycles.
- **Leading zero:** hours 05, BLANK_LZ=1 → idx5 seg=7F with an=1F; idx4 seg=12. Hours 00 → idx5 blank, idx4 seg=40. With BLANK_LZ=0 → idx5 seg=40.
- **Invalid BCD:** sec_low=4'hC → idx0 seg=7F. Other digits are unaffected.
- **Blink:** blink_sel=2, blink_phase=1 → idx2 and idx3 seg=7F and dp=1, with anodes still scanning. Set blink_phase=0 mid-slot in idx2 → seg=10 and dp=0 one cycle later.
- **Mid-slot change:** change min_low from 9 to 0 while idx=2 → seg changes from 10 to 40 on the next edge. an is unchanged.
